// File: rtl/uart_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_slave_pkg
// Desc     : Register map, bit indices and shared types for the RIB UART slave.
// Revision : 1.0 - initial release
// ============================================================================
package uart_slave_pkg;

    localparam logic [7:0] UART_CTRL   = 8'h00;
    localparam logic [7:0] UART_STATUS = 8'h04;
    localparam logic [7:0] UART_BAUD   = 8'h08;
    localparam logic [7:0] UART_TXDATA = 8'h0C;
    localparam logic [7:0] UART_RXDATA = 8'h10;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_INT_EN = 2;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;

    // Interconnect slave-select nibble (addr[31:28]) assigned to the UART
    localparam logic [3:0] RIB_SEL_UART = 4'h3;

    localparam logic [15:0] UART_MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [15:0] eff_div(input logic [15:0] baud);
        return (baud < UART_MIN_DIV) ? UART_MIN_DIV : baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_slave_if
// Desc     : RIB slave-port bundle; names follow the slave's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_slave_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;

    modport slave  (input  req_i, we_i, addr_i, data_i, output data_o, ack_o);
    modport master (output req_i, we_i, addr_i, data_i, input  data_o, ack_o);
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Desc     : rx_pin synchroniser and 8N1 receive FSM; one-cycle byte/err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        rx_en_i,
    input  wire logic [15:0] div_i,
    input  wire logic        rx_pin,
    output logic             byte_valid_o,
    output logic [7:0]       data_byte_o,
    output logic             frame_err_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   w_rx_s;
    logic                   w_fall;

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_q, bit_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    assign w_rx_s = sync_q[SYNC_STAGES-1];
    assign w_fall = prev_q & ~w_rx_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (!rx_en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_fall) begin
                        state_d = ST_START;
                        div_d   = div_i;
                        cnt_d   = (div_i >> 1) - 16'd1;
                    end
                end
                ST_START: begin
                    if (cnt_q == 16'd0) begin
                        // A line back high at mid-start-bit is treated as a glitch
                        state_d = w_rx_s ? ST_IDLE : ST_DATA;
                        cnt_d   = div_q - 16'd1;
                        bit_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == 16'd0) begin
                        sh_d  = {w_rx_s, sh_q[7:1]};
                        cnt_d = div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == 16'd0) begin
                        state_d = ST_IDLE;
                        valid_d = w_rx_s;
                        ferr_d  = ~w_rx_s;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            div_q   <= UART_MIN_DIV;
            sh_q    <= 8'd0;
            bit_q   <= 3'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_pin};
            prev_q  <= w_rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign data_byte_o  = sh_q;
    assign frame_err_o  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_slave.sv
`default_nettype none
// ============================================================================
// Module   : uart_slave
// Desc     : RIB UART slave: register file, 8N1 transmitter, RX buffer and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module uart_slave
    import uart_slave_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV_RST = 16'd434,
    parameter int          SYNC_STAGES  = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_slave_if.slave bus,
    input  wire logic  rx_pin,
    output logic       tx_pin,
    output logic       int_sig_o
);

    logic [7:0]  w_addr;
    logic        w_wr, w_rd, w_rd_rxdata, w_tx_load, w_tx_busy;
    logic [15:0] w_div;
    logic        w_rx_byte_valid, w_rx_frame_err;
    logic [7:0]  w_rx_byte;
    logic        unused_bus;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  rxbuf_q, rxbuf_d;
    logic        int_q, int_d;

    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_pin_q, tx_pin_d;

    assign w_addr      = bus.addr_i[7:0];
    assign w_wr        = bus.req_i & bus.we_i;
    assign w_rd        = bus.req_i & ~bus.we_i;
    assign w_rd_rxdata = w_rd && (w_addr == UART_RXDATA);
    assign w_tx_busy   = (tx_state_q != ST_IDLE);
    assign w_tx_load   = w_wr && (w_addr == UART_TXDATA) && ctrl_q[CTRL_TX_EN] && !w_tx_busy;
    assign w_div       = eff_div(baud_q);
    assign unused_bus  = ^{bus.addr_i[31:8], bus.data_i[31:16]};

    assign bus.ack_o = bus.req_i;

    always_comb begin
        bus.data_o = 32'h0;
        if (w_rd) begin
            case (w_addr)
                UART_CTRL:   bus.data_o[2:0]  = ctrl_q;
                UART_STATUS: begin
                    bus.data_o[ST_TX_BUSY]    = w_tx_busy;
                    bus.data_o[ST_RX_VALID]   = rx_valid_q;
                    bus.data_o[ST_RX_OVERRUN] = overrun_q;
                    bus.data_o[ST_FRAME_ERR]  = ferr_q;
                end
                UART_BAUD:   bus.data_o[15:0] = baud_q;
                UART_RXDATA: bus.data_o[7:0]  = rxbuf_q;
                default:     bus.data_o       = 32'h0;
            endcase
        end
    end

    // Hardware set events are applied after the clears so they win a collision
    always_comb begin
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        ferr_d     = ferr_q;
        rxbuf_d    = rxbuf_q;
        if (w_wr) begin
            case (w_addr)
                UART_CTRL: ctrl_d = bus.data_i[2:0];
                UART_BAUD: baud_d = bus.data_i[15:0];
                UART_STATUS: begin
                    if (bus.data_i[ST_RX_OVERRUN]) overrun_d = 1'b0;
                    if (bus.data_i[ST_FRAME_ERR])  ferr_d    = 1'b0;
                end
                default: ;
            endcase
        end
        if (w_rd_rxdata) rx_valid_d = 1'b0;
        if (w_rx_byte_valid) begin
            rxbuf_d    = w_rx_byte;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !w_rd_rxdata) overrun_d = 1'b1;
        end
        if (w_rx_frame_err) ferr_d = 1'b1;
        int_d = ctrl_q[CTRL_RX_INT_EN] & rx_valid_q;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_pin_d   = tx_pin_q;
        case (tx_state_q)
            ST_IDLE: begin
                tx_pin_d = 1'b1;
                if (w_tx_load) begin
                    tx_state_d = ST_START;
                    tx_div_d   = w_div;
                    tx_cnt_d   = w_div - 16'd1;
                    tx_sh_d    = bus.data_i[7:0];
                    tx_pin_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_pin_d   = tx_sh_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = tx_div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_pin_d   = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_pin_d = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = ST_IDLE;
                    tx_pin_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= 3'd0;
            baud_q     <= BAUD_DIV_RST;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            rxbuf_q    <= 8'd0;
            int_q      <= 1'b0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= UART_MIN_DIV;
            tx_sh_q    <= 8'd0;
            tx_bit_q   <= 3'd0;
            tx_pin_q   <= 1'b1;
        end else begin
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            rxbuf_q    <= rxbuf_d;
            int_q      <= int_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_pin_q   <= tx_pin_d;
        end
    end

    assign tx_pin    = tx_pin_q;
    assign int_sig_o = int_q;

    uart_rx_core #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_core (
        .clk          (clk),
        .rst          (rst),
        .rx_en_i      (ctrl_q[CTRL_RX_EN]),
        .div_i        (w_div),
        .rx_pin       (rx_pin),
        .byte_valid_o (w_rx_byte_valid),
        .data_byte_o  (w_rx_byte),
        .frame_err_o  (w_rx_frame_err)
    );

endmodule
`default_nettype wire

// File: doc/uart_slave.md
Name: uart_slave

Overview:
- UART peripheral on the RIB bus as a new slave alongside rom/ram/timer. It consumes the slave-port transactions the interconnect produces and drives pins tx_pin/rx_pin.
- Fixed 8N1 framing with a programmable baud divider. Single-byte TX holding register, single-byte RX buffer, and a level interrupt into the core's int_flag vector.

Parameters:
- BAUD_DIV_RST, 16'd434, reset value of the BAUD register (clk cycles per bit; 50 MHz / 115200).
- SYNC_STAGES, 2, number of rx_pin synchroniser flops (minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  RIB slave request
- we_i  in  1  write enable (1 = write)
- addr_i  in  32  byte address; only addr_i[7:0] decoded
- data_i  in  32  write data
- data_o  out  32  read data
- ack_o  out  1  transfer acknowledge
- rx_pin  in  1  serial input, asynchronous
- tx_pin  out  1  serial output, idle high
- int_sig_o  out  1  level interrupt

Behaviour:
Reset state:
- Reset: clk, rst, synchronous, active-high.
- All registers return to reset values on the rst clock edge. This applies mid-frame: TX and RX FSMs go to IDLE, tx_pin=1, rx_valid=0, flags=0, BAUD=BAUD_DIV_RST, CTRL=0.
- int_sig_o=0.

Bus protocol:
- Zero wait state. ack_o = req_i (combinational).
- data_o is a combinational decode of addr_i[7:0] while req_i && !we_i, else 32'h0.
- Write side effects occur on the clk edge with req_i && we_i.
- Read side effects occur on the clk edge with req_i && !we_i.
- Unmapped offsets read 0; writes to them are ignored.

Register map:
- 0x00 CTRL (rw): bit0 tx_en, bit1 rx_en, bit2 rx_int_en; other bits read 0.
- 0x04 STATUS:
  - bit0 tx_busy (ro)
  - bit1 rx_valid (ro)
  - bit2 rx_overrun (W1C)
  - bit3 frame_err (W1C)
- 0x08 BAUD (rw, bits [15:0]). The effective divider is max(BAUD,4). It is latched into each FSM at frame start, so a write mid-frame affects only later frames.
- 0x0C TXDATA (wo, bits [7:0]):
  - Write with tx_en=1 and tx_busy=0: load shifter, tx_busy=1 on the next cycle.
  - Write while busy or with tx_en=0: dropped silently.
- 0x10 RXDATA (ro, bits [7:0]): a read returns the buffered byte and clears rx_valid at that edge.

TX FSM (IDLE, START, DATA, STOP):
- Each state holds for exactly div cycles. DATA sends 8 bits LSB first.
- After STOP, return to IDLE and clear tx_busy. tx_pin idles high.
- Frame length is 10*div cycles from the TXDATA write edge +1.
- Clearing tx_en mid-frame does not abort the current frame.

RX FSM (IDLE, START, DATA, STOP):
- rx_pin goes through SYNC_STAGES flops. IDLE with rx_en=1 detects a synchronised 1->0 transition.
- START waits div/2 cycles. If the line is still 0, go to DATA; otherwise it is a glitch and the FSM returns to IDLE.
- DATA samples 8 bits at div-cycle spacing, LSB first. STOP samples once more after div cycles:
  - Sample = 1: byte written to buffer.
  - Sample = 0: frame_err=1 and the byte is discarded.
- Clearing rx_en mid-frame aborts to IDLE with no buffer update.

Buffer and interrupt boundaries:
- Byte completes while rx_valid=1: buffer overwritten, rx_overrun=1.
- Byte completes on the same edge as an RXDATA read: the new byte wins, rx_valid stays 1, no overrun.
- W1C write on the same edge as a flag set: the set wins.
- int_sig_o = rx_int_en & rx_valid, registered (one cycle after rx_valid rises).

Decomposition:
- The shared defines file gains:
  - UART register offset constants (UART_CTRL..UART_RXDATA)
  - CTRL/STATUS bit indices
  - The 4'h? RIB slave-select nibble for the UART
- One natural sub-module: uart_rx_core, containing the synchroniser, RX FSM and bit counter. It outputs a one-cycle byte_valid with data_byte and frame_err.
- TX FSM and registers live in uart_slave.

Test Plan:
- Reset: rst high 3 cycles. Check tx_pin=1, int_sig_o=0, read 0x08 = 434, read 0x04 = 0.
- TX: BAUD=4, CTRL=1, write TXDATA=0xA5. Check tx_pin = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. STATUS.bit0 reads 1 throughout and reads 0 after 40 cycles. A second TXDATA write during the frame is dropped.
- RX + interrupt: BAUD=8, CTRL=6. Drive 0x3C 8N1 on rx_pin at 8 cycles/bit. Check rx_valid=1, int_sig_o=1, read RXDATA=0x3C. After the read, rx_valid=0 and int_sig_o=0 one cycle later.
- Overrun/framing: receive 0x11 then 0x22 without reading. Check RXDATA=0x22 and STATUS=0x6. Write STATUS=0x4, then read STATUS=0x2. Send a frame with stop bit 0: STATUS.bit3=1 and RXDATA is unchanged.
- Glitch/abort: a 2-cycle low pulse on rx_pin with BAUD=8 produces no byte. Clearing rx_en mid-frame produces no byte and no error flags.
- Simultaneous: time an RXDATA read to the byte-complete edge. Check rx_valid stays 1 and rx_overrun stays 0.
